// File: rtl/number_analyzer_pkg.sv
// Shared definitions for the number analyzer and the blocks that schedule it.
//  - FSM state encoding for the analyzer scheduler.
//  - Bit positions of the analyzer result flags.
//  - Default operand width and fixed counter widths.
package number_analyzer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int FLAG_ODD = 0;
  localparam int FLAG_FIB = 1;
  localparam int FLAG_PAL = 2;
  localparam int FLAG_W   = 3;

  localparam int DEFAULT_WIDTH = 32;
  localparam int TIMER_W       = 8;
  localparam int JOBS_W        = 16;

endpackage

// File: rtl/number_analyzer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//  req       N      request vector
//  pointer   IW     highest-priority requester for this search
//  grant     N      one-hot grant (all zero when no request)
//  grant_idx IW     index of the granted requester (0 when no request)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] idx;
  logic          found;

  // Walk the requesters starting at the pointer, wrapping at N-1; the first
  // active one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = pointer;
    for (int i = 0; i < N; i++) begin
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
      idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/number_analyzer_scheduler.sv
// Shares one number_analyzer between NUM_REQ requesters.
// One job is in flight at a time: a round-robin grant latches the operand,
// the analyzer is enabled until it reports ready (or the watchdog fires),
// and the tagged result is held until the consumer takes it.
//  clock, reset   rising-edge clock, synchronous active-low reset
//  req_*          per-requester valid/operand in, one-hot accept strobe out
//  an_*           analyzer operand/enable out, ready/flags in
//  rsp_*          tagged response with valid/ready handshake
//  jobs_done      count of delivered responses, wraps at 16 bits
module number_analyzer_scheduler
  import number_analyzer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_number,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           an_number,
  output logic                       an_enable,
  input  logic                       an_ready,
  input  logic [FLAG_W-1:0]          an_flags,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_number,
  output logic [FLAG_W-1:0]          rsp_flags,
  output logic                       rsp_timeout,
  output logic [JOBS_W-1:0]          jobs_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        rr_ptr;
  logic [TIMER_W-1:0]   timer;
  logic [WIDTH-1:0]     number_q;
  logic [WIDTH-1:0]     sel_number;
  logic                 accept;
  logic                 timer_end;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .pointer   (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_number = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_number = req_number[i*WIDTH +: WIDTH];
    end
  end

  assign timer_end = (timer == TIMER_LAST);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // req_ready is gated by reset so no requester sees an accept strobe that
  // the reset is about to discard.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = '0;
    an_enable = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (reset && (|req_valid)) begin
          req_ready = grant;
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        an_enable = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        an_enable = 1'b1;
        if (an_ready || timer_end) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr      <= '0;
      number_q    <= '0;
      rsp_id      <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
      timer       <= '0;
      jobs_done   <= '0;
    end else begin
      if (accept) begin
        number_q <= sel_number;
        rsp_id   <= grant_idx;
        rr_ptr   <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == ISSUE) timer <= '0;
      // an_ready takes priority over the watchdog on the terminal cycle.
      if (state == WAIT) begin
        timer <= timer + 1'b1;
        if (an_ready) begin
          rsp_flags   <= an_flags;
          rsp_timeout <= 1'b0;
        end else if (timer_end) begin
          rsp_flags   <= '0;
          rsp_timeout <= 1'b1;
        end
      end
      if (rsp_valid && rsp_ready) jobs_done <= jobs_done + 1'b1;
    end
  end

  assign an_number  = number_q;
  assign rsp_number = number_q;

endmodule

// File: tb/tb_number_analyzer_scheduler.sv
module tb_number_analyzer_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_number = '0;
  logic [3:0]   req_ready;
  logic [31:0]  an_number;
  logic         an_enable;
  logic         an_ready;
  logic [2:0]   an_flags;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_number;
  logic [2:0]   rsp_flags;
  logic         rsp_timeout;
  logic [15:0]  jobs_done;

  always #5 clock = ~clock;

  number_analyzer_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_number(req_number), .req_ready(req_ready),
    .an_number(an_number), .an_enable(an_enable), .an_ready(an_ready), .an_flags(an_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_number(rsp_number), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .jobs_done(jobs_done)
  );

  // Real number analysis: {is_palindrome (decimal), is_fibonacci, is_odd}
  function automatic logic [2:0] analyze(input logic [31:0] n);
    longint a, b, t, m, r;
    logic fib, pal;
    fib = 1'b0; a = 0; b = 1;
    while (a <= longint'(n)) begin
      if (a == longint'(n)) fib = 1'b1;
      t = a + b; a = b; b = t;
    end
    m = longint'(n); r = 0;
    while (m > 0) begin
      r = r * 10 + m % 10;
      m = m / 10;
    end
    pal = (r == longint'(n));
    return {pal, fib, n[0]};
  endfunction

  // Analyzer model: ready once enable has been high for model_lat clocks
  int         model_lat = 255;
  int         en_cyc = 0;
  logic       flag_ovr_en = 1'b0;
  logic [2:0] flag_ovr = '0;
  always @(posedge clock) en_cyc <= an_enable ? en_cyc + 1 : 0;
  assign an_ready = an_enable && (en_cyc >= model_lat);
  assign an_flags = flag_ovr_en ? flag_ovr : analyze(an_number);

  typedef struct {
    int         id;
    logic [31:0] num;
    logic [2:0] flags;
    logic       to;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   exp_jobs = 0;
  int   ref_ptr = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s actual=missing required=present at %0t", name, $time);
  endfunction

  function automatic int ref_grant(input logic [3:0] m);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ref_ptr + k) % NUM_REQ;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rand_nums();
    logic [127:0] v;
    for (int i = 0; i < NUM_REQ; i++)
      v[i*32 +: 32] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 400)) : 32'($urandom);
    return v;
  endfunction

  // Monitor: pops expectations at each response handshake
  logic        rv_prev = 1'b0, rr_prev = 1'b0, en_prev = 1'b0;
  logic [31:0] num_prev = '0;
  logic [54:0] rsp_prev = '0;
  int          cyc = 0;

  initial begin
    forever begin
      @(negedge clock); #2;
      if (reset) begin
        if (an_enable && !en_prev) cyc = 0; else cyc++;
        if (en_prev && an_enable) check("an_number_stable", 64'(an_number), 64'(num_prev));
        if (rsp_valid) check("enable_low_in_resp", 64'(an_enable), 64'(0));
        if (rv_prev && !rr_prev) begin
          check("rsp_hold", 64'({rsp_valid, rsp_id, rsp_number, rsp_flags, rsp_timeout, jobs_done}),
                64'(rsp_prev));
          check("req_ready_blocked", 64'(req_ready), 64'(0));
        end
        if (rsp_valid && !rv_prev) begin
          if (exp_q.size() == 0) fail_now("unexpected_rsp");
          else check("latency", 64'(cyc), 64'(exp_q[0].lat));
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_number", 64'(rsp_number), 64'(e.num));
          check("rsp_flags", 64'(rsp_flags), 64'(e.flags));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          check("jobs_done", 64'(jobs_done), 64'(exp_jobs[15:0]));
          exp_jobs++;
        end
      end else begin
        cyc = 0;
      end
      rv_prev  = rsp_valid;
      rr_prev  = rsp_ready;
      en_prev  = an_enable;
      num_prev = an_number;
      rsp_prev = {rsp_valid, rsp_id, rsp_number, rsp_flags, rsp_timeout, jobs_done};
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req_valid = 4'hF;
    exp_q.delete();
    exp_jobs = 0;
    ref_ptr = 0;
    @(negedge clock);
    @(negedge clock); #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_an_enable", 64'(an_enable), 64'(0));
    check("rst_an_number", 64'(an_number), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_fields", 64'({rsp_id, rsp_flags, rsp_timeout}), 64'(0));
    check("rst_jobs_done", 64'(jobs_done), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    req_valid = '0;
  endtask

  // One job; bp<0 random rsp_ready, bp==0 always ready, bp>0 hold ready low
  // for bp cycles after rsp_valid appears.
  task automatic do_job(input logic [3:0] mask, input logic [127:0] nums, input int lat,
                        input logic ovr_en, input logic [2:0] ovr, input int bp);
    int   g, low;
    logic got, done, seen;
    exp_t e;
    @(negedge clock);
    model_lat   = lat;
    flag_ovr_en = ovr_en;
    flag_ovr    = ovr;
    req_valid   = mask;
    req_number  = nums;
    rsp_ready   = (bp < 0) ? ($urandom_range(0, 3) != 0) : (bp == 0);
    g = ref_grant(mask);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      if (req_ready != 0) got = 1'b1;
    end
    if (!got) begin
      fail_now("accept_wait");
      return;
    end
    check("grant", 64'(req_ready), 64'(4'(1) << g));
    e.id    = g;
    e.num   = nums[g*32 +: 32];
    e.to    = (lat > TIMEOUT);
    e.flags = e.to ? 3'b000 : (ovr_en ? ovr : analyze(e.num));
    e.lat   = e.to ? TIMEOUT + 1 : lat + 1;
    exp_q.push_back(e);
    ref_ptr = (g + 1) % NUM_REQ;
    done = 1'b0; seen = 1'b0; low = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clock);
      if (bp < 0)       rsp_ready = ($urandom_range(0, 3) != 0);
      else if (bp == 0) rsp_ready = 1'b1;
      else              rsp_ready = seen && (low >= bp);
      #1;
      if (rsp_valid) begin
        if (rsp_ready) done = 1'b1;
        else begin
          seen = 1'b1;
          low++;
        end
      end
    end
    if (!done) fail_now("rsp_wait");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] nums;
    logic         got;
    do_reset();

    // Single job from requester 2, operand 13, analyzer latency 5
    nums = rand_nums();
    nums[2*32 +: 32] = 32'd13;
    do_job(4'b0100, nums, 5, 1'b1, 3'b111, 0);

    do_reset();

    // Round robin with all requests held: 0,1,2,3,0
    repeat (5) do_job(4'hF, rand_nums(), 2, 1'b0, 3'b000, 0);

    // Watchdog: analyzer too slow, then ready exactly on the terminal cycle
    do_job(4'b0010, rand_nums(), 9, 1'b0, 3'b000, 0);
    do_job(4'b0010, rand_nums(), 8, 1'b0, 3'b000, 0);

    // Backpressure for 10 cycles
    do_job(4'b1001, rand_nums(), 3, 1'b0, 3'b000, 10);

    // Randomized traffic
    repeat (40) do_job(4'($urandom_range(1, 15)), rand_nums(), $urandom_range(1, 10),
                       1'b0, 3'b000, -1);

    // Reset in the middle of WAIT: job dropped, arbitration restarts at 0
    @(negedge clock);
    model_lat = 255;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    got = (req_ready != 0);
    check("midwait_grant", 64'(req_ready), 64'(4'b0100));
    @(negedge clock);
    req_valid = '0;
    repeat (3) @(negedge clock);
    #1;
    check("midwait_enable", 64'(an_enable), 64'(got));
    do_reset();
    do_job(4'hF, rand_nums(), 4, 1'b0, 3'b000, 0);
    @(negedge clock);
    req_valid = '0;
    repeat (12) @(negedge clock);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("jobs_done_final", 64'(jobs_done), 64'(exp_jobs[15:0]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
